// File: rtl/ppu_frame_timer.sv
// ppu_frame_timer
//
// Dot/scanline beam timing for the PPU. It sits in front of the PPUSTATUS
// ($2002) register and drives that register's vblank set/clear strobes. It
// also exports the beam position and frame-phase flags to the background and
// sprite fetch logic.
//
// Timing features:
//   - NTSC odd-frame dot skip: on odd frames with rendering enabled, dot 340
//     of the pre-render line is skipped.
//   - $2002-read vblank suppression race: a read at (VBLANK_LINE, 0) withholds
//     that frame's VBLANK_set pulse.
//
// Ports:
//   Clk             system clock
//   Reset_n         asynchronous active-low reset
//   Dot_en          dot strobe; position advances only on edges where it is 1
//   Rendering_en    PPUMASK bit3 | bit4, sampled only on the skip cycle
//   PPUSTATUS_read  single-cycle CPU read strobe for $2002
//   VBLANK_set      one-Clk pulse after (VBLANK_LINE, 1) is loaded
//   VBLANK_clear    one-Clk pulse after (PRERENDER_LINE, 1) is loaded
//   Dot             current dot, 0..DOTS_PER_LINE-1
//   Scanline        current scanline, 0..LINES_PER_FRAME-1
//   Odd_frame       frame parity
//   Visible         Scanline < VISIBLE_LINES
//   Prerender       Scanline == PRERENDER_LINE
//   Frame_start     one-Clk pulse after (0, 0) is loaded
module ppu_frame_timer #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241,
    parameter int PRERENDER_LINE  = 261,
    parameter int VISIBLE_LINES   = 240
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Dot_en,
    input  logic       Rendering_en,
    input  logic       PPUSTATUS_read,
    output logic       VBLANK_set,
    output logic       VBLANK_clear,
    output logic [8:0] Dot,
    output logic [8:0] Scanline,
    output logic       Odd_frame,
    output logic       Visible,
    output logic       Prerender,
    output logic       Frame_start
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_SKIP  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] LINE_VBL  = 9'(VBLANK_LINE);
    localparam logic [8:0] LINE_PRE  = 9'(PRERENDER_LINE);
    localparam logic [8:0] LINE_VIS  = 9'(VISIBLE_LINES);

    logic [8:0] dot_d;
    logic [8:0] line_d;
    logic       odd_d;
    logic       skip;
    logic       at_vbl0;
    logic       load_vbl1;
    logic       load_pre1;
    logic       load_origin;
    logic       suppress_q;
    logic       suppress_now;
    logic       suppress_d;
    logic       set_d;

    // Next beam position.
    always_comb begin
        dot_d  = Dot;
        line_d = Scanline;
        odd_d  = Odd_frame;
        skip   = Dot_en && Odd_frame && Rendering_en &&
                 (Scanline == LINE_PRE) && (Dot == DOT_SKIP);
        if (Dot_en) begin
            if (skip) begin
                dot_d  = '0;
                line_d = '0;
                odd_d  = ~Odd_frame;
            end else if (Dot < DOT_LAST) begin
                dot_d = Dot + 9'd1;
            end else begin
                dot_d = '0;
                if (Scanline == LINE_LAST) begin
                    line_d = '0;
                    odd_d  = ~Odd_frame;
                end else begin
                    line_d = Scanline + 9'd1;
                end
            end
        end
    end

    // Positions loaded on this edge; the pulses are registered one cycle later.
    always_comb begin
        load_vbl1   = Dot_en && (line_d == LINE_VBL) && (dot_d == 9'd1);
        load_pre1   = Dot_en && (line_d == LINE_PRE) && (dot_d == 9'd1);
        load_origin = Dot_en && (line_d == 9'd0)     && (dot_d == 9'd0);
    end

    // A read anywhere during (VBLANK_LINE, 0), including the very cycle that
    // advances to dot 1, must win over that same edge's set pulse, so the
    // live read is folded in rather than waiting for the flag to register.
    always_comb begin
        at_vbl0      = (Scanline == LINE_VBL) && (Dot == 9'd0);
        suppress_now = suppress_q | (PPUSTATUS_read & at_vbl0);
        suppress_d   = load_vbl1 ? 1'b0 : suppress_now;
        set_d        = load_vbl1 & ~suppress_now;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Dot          <= '0;
            Scanline     <= '0;
            Odd_frame    <= 1'b0;
            VBLANK_set   <= 1'b0;
            VBLANK_clear <= 1'b0;
            Frame_start  <= 1'b0;
            suppress_q   <= 1'b0;
        end else begin
            Dot          <= dot_d;
            Scanline     <= line_d;
            Odd_frame    <= odd_d;
            VBLANK_set   <= set_d;
            VBLANK_clear <= load_pre1;
            Frame_start  <= load_origin;
            suppress_q   <= suppress_d;
        end
    end

    assign Visible   = (Scanline < LINE_VIS);
    assign Prerender = (Scanline == LINE_PRE);

endmodule

// File: tb/tb_ppu_frame_timer.sv
module tb_ppu_frame_timer;

    // Shrunk geometry keeps full frames affordable; all rules are unchanged.
    localparam int DPL   = 12;
    localparam int LPF   = 10;
    localparam int VBL   = 6;
    localparam int PRE   = 9;
    localparam int VIS   = 5;
    localparam int FRAME = DPL * LPF;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       Dot_en = 1'b0;
    logic       Rendering_en = 1'b0;
    logic       PPUSTATUS_read = 1'b0;
    logic       VBLANK_set, VBLANK_clear, Odd_frame, Visible, Prerender, Frame_start;
    logic [8:0] Dot, Scanline;

    ppu_frame_timer #(
        .DOTS_PER_LINE  (DPL),
        .LINES_PER_FRAME(LPF),
        .VBLANK_LINE    (VBL),
        .PRERENDER_LINE (PRE),
        .VISIBLE_LINES  (VIS)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Dot_en        (Dot_en),
        .Rendering_en  (Rendering_en),
        .PPUSTATUS_read(PPUSTATUS_read),
        .VBLANK_set    (VBLANK_set),
        .VBLANK_clear  (VBLANK_clear),
        .Dot           (Dot),
        .Scanline      (Scanline),
        .Odd_frame     (Odd_frame),
        .Visible       (Visible),
        .Prerender     (Prerender),
        .Frame_start   (Frame_start)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [8:0] dot;
        logic [8:0] line;
        logic       odd, vs, vc, fs, vis, pre;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: beam position is a linear dot index within the frame.
    int   m_k = 0;
    int   m_fedges = 0;
    int   edges_since = 0;
    bit   m_odd = 1'b0;
    bit   m_sup = 1'b0;
    exp_t mon_e;

    // Monitor: every edge that had stimulus queued gets compared.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if ({Dot, Scanline, Odd_frame, VBLANK_set, VBLANK_clear, Frame_start, Visible, Prerender} !==
                {mon_e.dot, mon_e.line, mon_e.odd, mon_e.vs, mon_e.vc, mon_e.fs, mon_e.vis, mon_e.pre}) begin
                n_miss++;
                $display("FAIL beam t=%0t got dot=%0d line=%0d odd=%0b set=%0b clr=%0b fs=%0b vis=%0b pre=%0b want dot=%0d line=%0d odd=%0b set=%0b clr=%0b fs=%0b vis=%0b pre=%0b",
                         $time, Dot, Scanline, Odd_frame, VBLANK_set, VBLANK_clear, Frame_start, Visible, Prerender,
                         mon_e.dot, mon_e.line, mon_e.odd, mon_e.vs, mon_e.vc, mon_e.fs, mon_e.vis, mon_e.pre);
            end
        end
    end

    function automatic int cur_line();
        return m_k / DPL;
    endfunction

    function automatic int cur_dot();
        return m_k % DPL;
    endfunction

    task automatic model_reset();
        m_k = 0;
        m_odd = 1'b0;
        m_sup = 1'b0;
        m_fedges = 0;
        edges_since = 0;
        len_q.delete();
    endtask

    // Drive one cycle at the falling edge and queue what the next rising edge must produce.
    task automatic step(input bit de, input bit rend, input bit rd);
        exp_t e;
        int   l;
        @(negedge Clk);
        if (Frame_start === 1'b1) begin
            n_vec++;
            if (len_q.size() == 0) begin
                n_miss++;
                $display("FAIL frame_len got start after %0d edges want no frame end", edges_since);
            end else begin
                l = len_q.pop_front();
                if (l != edges_since) begin
                    n_miss++;
                    $display("FAIL frame_len got %0d edges want %0d", edges_since, l);
                end
            end
            edges_since = 0;
        end
        Dot_en = de;
        Rendering_en = rend;
        PPUSTATUS_read = rd;
        e.vs = 1'b0;
        e.vc = 1'b0;
        e.fs = 1'b0;
        if (rd && cur_line() == VBL && cur_dot() == 0) m_sup = 1'b1;
        if (de) begin
            edges_since++;
            m_fedges++;
            if (m_odd && rend && m_k == PRE * DPL + DPL - 2) m_k = FRAME;
            else m_k++;
            if (m_k == FRAME) begin
                m_k = 0;
                m_odd = ~m_odd;
                e.fs = 1'b1;
                len_q.push_back(m_fedges);
                m_fedges = 0;
            end
            if (m_k == VBL * DPL + 1) begin
                e.vs = ~m_sup;
                m_sup = 1'b0;
            end
            if (m_k == PRE * DPL + 1) e.vc = 1'b1;
        end
        e.dot  = 9'(cur_dot());
        e.line = 9'(cur_line());
        e.odd  = m_odd;
        e.vis  = (cur_line() < VIS);
        e.pre  = (cur_line() == PRE);
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if ({Dot, Scanline, Odd_frame, VBLANK_set, VBLANK_clear, Frame_start} !== 23'd0) begin
            n_miss++;
            $display("FAIL %s got dot=%0d line=%0d odd=%0b set=%0b clr=%0b fs=%0b want all zero",
                     name, Dot, Scanline, Odd_frame, VBLANK_set, VBLANK_clear, Frame_start);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge.
    task automatic do_reset(input int hold);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        Dot_en = 1'b0;
        Rendering_en = 1'b0;
        PPUSTATUS_read = 1'b0;
        model_reset();
        repeat (hold) @(negedge Clk);
        check_reset_outputs("held_reset");
        #2 Reset_n = 1'b1;
    endtask

    task automatic run_to(input int line, input int dot, input int budget, input bit rend);
        int n = 0;
        while (!(cur_line() == line && cur_dot() == dot) && n < budget) begin
            step(1'($urandom_range(0, 1)), rend, 1'b0);
            n++;
        end
        if (!(cur_line() == line && cur_dot() == dot)) begin
            n_vec++;
            n_miss++;
            $display("FAIL run_to got line=%0d dot=%0d want line=%0d dot=%0d", cur_line(), cur_dot(), line, dot);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        // 1-2: reset, free-running dots, no rendering.
        do_reset(3);
        repeat (2 * FRAME + 10) step(1'b1, 1'b0, 1'b0);

        // 3: rendering on from reset: frames of FRAME, FRAME-1, FRAME.
        do_reset(2);
        repeat (3 * FRAME + 5) step(1'b1, 1'b1, 1'b0);

        // 4: suppressing read at (VBL,0), then next frame normal, then a read at (VBL,2).
        run_to(VBL, 0, 4 * FRAME, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (FRAME + 3) step(1'b1, 1'b0, 1'b0);
        run_to(VBL, 2, 4 * FRAME, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        run_to(VBL, 0, 4 * FRAME, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (FRAME) step(1'b1, 1'b1, 1'b0);

        // 5: one dot every fourth clock.
        for (int i = 0; i < 2 * FRAME * 4; i++) step(i % 4 == 0, 1'b1, 1'b0);

        // Randomized dots, rendering and reads.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

        // 6: mid-frame reset, then a full frame and a bit.
        run_to(4, 7, 4 * FRAME, 1'b0);
        do_reset(4);
        repeat (FRAME + 20) step(1'b1, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        n_vec++;
        if (len_q.size() != 0) begin
            n_miss++;
            $display("FAIL frame_start_missing got %0d unmatched frame ends want 0", len_q.size());
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ppu_frame_timer.md
Name: ppu_frame_timer

Overview:
- Dot/scanline timing generator for the PPU.
- Sits directly upstream of the PPUSTATUS ($2002) register and drives its VBLANK_set and VBLANK_clear inputs.
- Also exports the current beam position and frame-phase flags to the background/sprite fetch logic.
- Implements the NTSC odd-frame dot skip and the $2002-read vblank suppression race.

Parameters:
- DOTS_PER_LINE, 341, dots per scanline (dot range 0..DOTS_PER_LINE-1)
- LINES_PER_FRAME, 262, scanlines per frame (line range 0..LINES_PER_FRAME-1)
- VBLANK_LINE, 241, scanline on which the vblank flag is set
- PRERENDER_LINE, 261, scanline on which the vblank flag is cleared; also the odd-frame skip line

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- Dot_en  in  1  PPU dot strobe; counters advance only on Clk edges where Dot_en=1
- Rendering_en  in  1  PPUMASK bit3 | bit4
- PPUSTATUS_read  in  1  single-cycle CPU read strobe for $2002
- VBLANK_set  out  1  one-Clk pulse to reg2002
- VBLANK_clear  out  1  one-Clk pulse to reg2002
- Dot  out  9  current dot
- Scanline  out  9  current scanline
- Odd_frame  out  1  frame parity
- Visible  out  1  Scanline < 240
- Prerender  out  1  Scanline == PRERENDER_LINE
- Frame_start  out  1  one-Clk pulse when position becomes (0,0)

Behaviour:
- **Reset.** Reset_n low asynchronously forces:
  - Dot=0, Scanline=0, Odd_frame=0
  - VBLANK_set=0, VBLANK_clear=0, Frame_start=0
  - internal suppress flag=0
- **Reset mid-frame** aborts the frame. After release, counting restarts from (0,0) on the next Dot_en.
- **Counter advance.** On a Clk edge with Dot_en=1:
  - If Dot < DOTS_PER_LINE-1: Dot++.
  - Otherwise: Dot=0 and Scanline++.
  - If Dot and Scanline both wrap: Scanline=0 and Odd_frame toggles.
  - With Dot_en=0, all counters hold.
- **Odd-frame skip.** Condition: Scanline==PRERENDER_LINE, Dot==DOTS_PER_LINE-2 (339), Odd_frame=1, Rendering_en=1, Dot_en=1.
  - Next position is (0,0) and Odd_frame toggles; dot 340 is skipped.
  - Rendering_en is sampled only on that cycle.
- **Registered output pulses.** Each is high for exactly one Clk cycle, the cycle immediately after the Dot_en edge that loads the named position; low in all other cycles, including while Dot_en=0:
  - VBLANK_set: position (VBLANK_LINE, 1), unless suppressed.
  - VBLANK_clear: position (PRERENDER_LINE, 1), unconditional.
  - Frame_start: position (0,0), by normal wrap or by skip.
- **Suppression.** PPUSTATUS_read=1 in any Clk cycle while position==(VBLANK_LINE, 0) sets the suppress flag.
  - The next VBLANK_set pulse is then withheld.
  - The flag clears when position (VBLANK_LINE, 1) is loaded (suppressed or not) and on reset.
  - Reads at any other position have no effect on this block.
- **Combinational decodes.** Visible and Prerender are decoded from the registered Scanline.
- **Output width.** Dot and Scanline are always within their ranges; values ≥ the parameter limits never appear.
- **Simultaneous events.**
  - PPUSTATUS_read in the same cycle as a VBLANK_set pulse is not suppression; reg2002 resolves that priority.
  - VBLANK_set and VBLANK_clear are never high together.

Test Plan:
1. **Reset and first set.** Reset_n low, then high; Dot_en=1 every cycle, Rendering_en=0.
   - Dot=0, Scanline=0 during reset.
   - VBLANK_set pulses once, one cycle after Dot_en edge #82182 (position 241,1).
2. **Clear timing.** Same run as scenario 1.
   - VBLANK_clear pulses after Dot_en edge #89002 (position 261,1).
   - Frame_start pulses after edge #89342.
   - Odd_frame=1 after that edge.
3. **Odd-frame skip.** Rendering_en=1 for 3 frames.
   - Frame lengths are 89342, 89341, 89342 Dot_en edges.
   - Dot never shows 340 on the odd frame's prerender line.
   - Repeat with Rendering_en=0: all frames are 89342.
4. **Suppression.** PPUSTATUS_read pulsed at position (241,0).
   - No VBLANK_set that frame; VBLANK_clear still pulses.
   - The next frame's VBLANK_set is normal.
   - A read at (241,2) causes no change.
5. **Dot_en gating.** Dot_en=1 every 4th cycle.
   - Counters advance once per 4 Clk cycles.
   - Each pulse is still exactly 1 Clk wide.
6. **Reset mid-frame.** Assert Reset_n=0 at (120,200).
   - Outputs go to reset values immediately, without waiting for Clk.
   - After release, VBLANK_set occurs 82182 Dot_en edges later.
